// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants used by the shared-port blocks.
package cpu_pkg;

  localparam int CPU_DATA_W = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: lowest request at or after ptr wins,
// wrapping from N-1 back to 0.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N-1:0]     gnt_onehot,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_any
);

  int idx;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    gnt_any    = 1'b0;
    idx        = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!gnt_any && req[idx]) begin
        gnt_any         = 1'b1;
        gnt_idx         = SEL_W'(idx);
        gnt_onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_mux_nx1.sv
// N:1 registered multiplexer with valid/ready channels, round-robin
// arbitration and a fixed-select override.
module rr_mux_nx1
  import cpu_pkg::*;
#(
  parameter int WIDTH = CPU_DATA_W,
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               force_en,
  input  logic [SEL_W-1:0]   force_sel,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [SEL_W-1:0] ptr;
  logic [N-1:0]     arb_onehot;
  logic [SEL_W-1:0] arb_idx;
  logic             arb_any;

  logic             load_en;
  logic [N-1:0]     gnt_onehot;
  logic [SEL_W-1:0] gnt_idx;
  logic             gnt_any;
  logic [WIDTH-1:0] gnt_data;

  rr_arbiter #(.N(N), .SEL_W(SEL_W)) u_arb (
    .req        (in_valid),
    .ptr        (ptr),
    .gnt_onehot (arb_onehot),
    .gnt_idx    (arb_idx),
    .gnt_any    (arb_any)
  );

  assign load_en = !out_valid || out_ready;

  // Force mode bypasses the arbiter; an out-of-range force_sel matches nothing.
  always_comb begin
    gnt_onehot = arb_onehot;
    gnt_idx    = arb_idx;
    gnt_any    = arb_any;
    if (force_en) begin
      gnt_onehot = '0;
      gnt_idx    = '0;
      gnt_any    = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (force_sel == SEL_W'(i) && in_valid[i]) begin
          gnt_onehot[i] = 1'b1;
          gnt_idx       = SEL_W'(i);
          gnt_any       = 1'b1;
        end
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_onehot[i]) gnt_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign in_ready = (rst_n && load_en) ? gnt_onehot : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (load_en) begin
      out_valid <= gnt_any;
      if (gnt_any) begin
        out_data <= gnt_data;
        out_sel  <= gnt_idx;
        if (!force_en) begin
          ptr <= (gnt_idx == SEL_W'(N-1)) ? '0 : gnt_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_nx1.sv
// Bench for rr_mux_nx1: table vectors plus a reference model/scoreboard on
// the N=4 instance, with small N=3 and N=2 instances for their corner cases.
module tb_rr_mux_nx1;

  localparam int W = 32;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid, in_ready;
  logic           force_en;
  logic [1:0]     force_sel;
  logic [W-1:0]   out_data;
  logic [1:0]     out_sel;
  logic           out_valid, out_ready;

  logic [3*W-1:0] in_data3;
  logic [2:0]     in_valid3, in_ready3;
  logic           force_en3;
  logic [1:0]     force_sel3;
  logic [W-1:0]   out_data3;
  logic [1:0]     out_sel3;
  logic           out_valid3, out_ready3;

  logic [2*W-1:0] in_data2;
  logic [1:0]     in_valid2, in_ready2;
  logic           force_en2;
  logic           force_sel2;
  logic [W-1:0]   out_data2;
  logic           out_sel2;
  logic           out_valid2, out_ready2;

  rr_mux_nx1 #(.WIDTH(W), .N(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .force_en(force_en), .force_sel(force_sel),
    .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  rr_mux_nx1 #(.WIDTH(W), .N(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .force_en(force_en3), .force_sel(force_sel3),
    .out_data(out_data3), .out_sel(out_sel3), .out_valid(out_valid3),
    .out_ready(out_ready3)
  );

  rr_mux_nx1 #(.WIDTH(W), .N(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data2), .in_valid(in_valid2),
    .in_ready(in_ready2), .force_en(force_en2), .force_sel(force_sel2),
    .out_data(out_data2), .out_sel(out_sel2), .out_valid(out_valid2),
    .out_ready(out_ready2)
  );

  typedef struct packed {
    logic [W-1:0] d;
    logic [1:0]   s;
  } beat_t;

  typedef struct {
    logic [3:0] v;
    logic       fe;
    logic [1:0] fs;
    logic [3:0] rdy;
  } vec_t;

  int           checks, errors;
  logic [W-1:0] dat [N];
  beat_t        sbq [$];
  vec_t         tbl [$];
  int           m_ptr;
  logic         m_valid;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic set_data();
    for (int i = 0; i < N; i++) in_data[i*W +: W] = dat[i];
  endtask

  function automatic logic [N-1:0] mgrant(input logic [N-1:0] v, input logic fe,
                                          input logic [1:0] fs, input int p);
    logic [N-1:0] g;
    int j;
    g = '0;
    if (fe) begin
      if (v[fs]) g[fs] = 1'b1;
    end else begin
      for (int k = 0; k < N; k++) begin
        j = (p + k) % N;
        if (v[j] && g == '0) g[j] = 1'b1;
      end
    end
    return g;
  endfunction

  // Called just after a falling edge with inputs set; advances one cycle.
  task automatic step(input string tag);
    logic [N-1:0] g, exp_rdy;
    logic le;
    int idx;
    #1;
    le = !m_valid || out_ready;
    g = mgrant(in_valid, force_en, force_sel, m_ptr);
    exp_rdy = le ? g : '0;
    chk({tag, " in_ready"}, 64'(in_ready), 64'(exp_rdy));
    chk({tag, " out_valid"}, 64'(out_valid), 64'(m_valid));
    if (m_valid && sbq.size() > 0) begin
      chk({tag, " out_data"}, 64'(out_data), 64'(sbq[0].d));
      chk({tag, " out_sel"}, 64'(out_sel), 64'(sbq[0].s));
      if (out_ready) void'(sbq.pop_front());
    end
    if (le) begin
      m_valid = |g;
      if (|g) begin
        idx = 0;
        for (int i = 0; i < N; i++) if (g[i]) idx = i;
        sbq.push_back('{d: dat[idx], s: 2'(idx)});
        if (!force_en) m_ptr = (idx + 1) % N;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    checks = 0; errors = 0; m_ptr = 0; m_valid = 1'b0;
    for (int i = 0; i < N; i++) dat[i] = 32'hA000_0000 + 32'(i);
    set_data();
    in_valid = 4'hF; force_en = 1'b0; force_sel = 2'd0; out_ready = 1'b1;
    in_data3 = {32'hC000_0002, 32'hC000_0001, 32'hC000_0000};
    in_valid3 = 3'b000; force_en3 = 1'b0; force_sel3 = 2'd0; out_ready3 = 1'b1;
    in_data2 = {32'h2222_0001, 32'h1111_0000};
    in_valid2 = 2'b00; force_en2 = 1'b0; force_sel2 = 1'b0; out_ready2 = 1'b1;

    #1 rst_n = 1'b0;
    #2;
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset out_data", 64'(out_data), 64'd0);
    chk("reset out_sel", 64'(out_sel), 64'd0);
    chk("reset in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // fairness, force (ptr held), force with channel off, sparse wrap, idle
    for (int i = 0; i < 6; i++) tbl.push_back('{4'hF, 1'b0, 2'd0, 4'(1 << (i % 4))});
    tbl.push_back('{4'hF, 1'b0, 2'd0, 4'b0100});
    for (int i = 0; i < 3; i++) tbl.push_back('{4'hF, 1'b1, 2'd1, 4'b0010});
    tbl.push_back('{4'hF, 1'b0, 2'd0, 4'b1000});
    tbl.push_back('{4'b1101, 1'b1, 2'd1, 4'b0000});
    tbl.push_back('{4'b0100, 1'b0, 2'd0, 4'b0100});
    tbl.push_back('{4'b0101, 1'b0, 2'd0, 4'b0001});
    tbl.push_back('{4'b0101, 1'b0, 2'd0, 4'b0100});
    tbl.push_back('{4'b0101, 1'b0, 2'd0, 4'b0001});
    tbl.push_back('{4'b0000, 1'b0, 2'd0, 4'b0000});
    tbl.push_back('{4'b0000, 1'b0, 2'd0, 4'b0000});

    for (int i = 0; i < tbl.size(); i++) begin
      in_valid = tbl[i].v; force_en = tbl[i].fe; force_sel = tbl[i].fs;
      #1;
      chk($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'(tbl[i].rdy));
      step($sformatf("vec%0d", i));
    end
    #1;
    chk("idle out_valid", 64'(out_valid), 64'd0);
    chk("idle out_data held", 64'(out_data), 64'hA000_0000);
    chk("idle out_sel held", 64'(out_sel), 64'd0);
    @(negedge clk);

    // backpressure with a held beat from channel 2
    dat[2] = 32'hDEAD_BEEF; set_data();
    in_valid = 4'b0100; out_ready = 1'b1;
    step("bp load");
    out_ready = 1'b0; in_valid = 4'hF;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp hold data", 64'(out_data), 64'hDEAD_BEEF);
      chk("bp hold valid", 64'(out_valid), 64'd1);
      step("bp hold");
    end
    out_ready = 1'b1;
    step("bp release");
    in_valid = 4'h0;
    step("bp drain");

    // asynchronous reset while a beat is held
    in_valid = 4'hF; out_ready = 1'b0;
    step("pre reset");
    #2 rst_n = 1'b0;
    #1;
    chk("async rst out_valid", 64'(out_valid), 64'd0);
    chk("async rst out_data", 64'(out_data), 64'd0);
    chk("async rst out_sel", 64'(out_sel), 64'd0);
    chk("async rst in_ready", 64'(in_ready), 64'd0);
    m_valid = 1'b0; m_ptr = 0; sbq.delete();
    @(negedge clk);
    rst_n = 1'b1; in_valid = 4'b1110; out_ready = 1'b1;
    step("post reset");
    in_valid = 4'h0;
    step("post reset drain");

    // N=3: force_sel beyond the last channel never grants
    in_valid3 = 3'b111; force_en3 = 1'b1; force_sel3 = 2'd3;
    #1 chk("n3 sel3 in_ready", 64'(in_ready3), 64'd0);
    @(negedge clk); #1;
    chk("n3 sel3 out_valid", 64'(out_valid3), 64'd0);
    force_sel3 = 2'd2;
    #1 chk("n3 sel2 in_ready", 64'(in_ready3), 64'b100);
    @(negedge clk); #1;
    chk("n3 sel2 out_valid", 64'(out_valid3), 64'd1);
    chk("n3 sel2 out_data", 64'(out_data3), 64'hC000_0002);
    chk("n3 sel2 out_sel", 64'(out_sel3), 64'd2);
    @(negedge clk);

    // N=2 forced: registered 2:1 mux with toggling select
    begin
      logic [W-1:0] exp_d;
      logic         exp_s;
      exp_d = '0; exp_s = 1'b0;
      in_valid2 = 2'b11; force_en2 = 1'b1;
      for (int i = 0; i < 7; i++) begin
        force_sel2 = 1'(i % 2);
        #1;
        chk("n2 in_ready", 64'(in_ready2), 64'(2'b01 << (i % 2)));
        if (i > 0) begin
          chk("n2 out_data", 64'(out_data2), 64'(exp_d));
          chk("n2 out_sel", 64'(out_sel2), 64'(exp_s));
          chk("n2 out_valid", 64'(out_valid2), 64'd1);
        end
        exp_s = force_sel2;
        exp_d = force_sel2 ? 32'h2222_0001 : 32'h1111_0000;
        @(negedge clk);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
